// File: rtl/vec_bram_if.sv
// Bus bundle for vec_bram: write port, single-read port, burst sequencer controls and read return.
// The master modport drives requests. The slave modport is the memory side.
interface vec_bram_if #(
    parameter int LANE_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int DEPTH      = 256
);
    localparam int W  = LANES * LANE_WIDTH;
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic [LANES-1:0] wr_mask;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             burst_start;
    logic [AW-1:0]    burst_base;
    logic [AW:0]      burst_len;
    logic [AW-1:0]    burst_stride;
    logic             burst_busy;
    logic             burst_done;
    logic [W-1:0]     rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic             rd_conflict;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
               burst_start, burst_base, burst_len, burst_stride,
        input  burst_busy, burst_done, rd_data, rd_valid, rd_last, rd_conflict
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
               burst_start, burst_base, burst_len, burst_stride,
        output burst_busy, burst_done, rd_data, rd_valid, rd_last, rd_conflict
    );
endinterface

// File: rtl/vec_bram.sv
// Lane-masked vector memory with a strided burst-read sequencer. Read-first, with no backpressure.
// Read latency is 1 cycle. With VEC_BRAM_OUTREG_EN defined, an output register stage is added and latency is 2.
module vec_bram #(
    parameter int LANE_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int DEPTH      = 256
) (
    input  logic       clk,
    input  logic       rst,
    vec_bram_if.slave  bus
);
    localparam int W  = LANES * LANE_WIDTH;
    localparam int AW = $clog2(DEPTH);
`ifdef VEC_BRAM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam logic       DRAIN_INIT = 1'(L - 1);
    localparam logic [AW:0] ONE       = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        r_state;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_stride;
    logic [AW:0]   r_len;
    logic [AW:0]   r_cnt;
    logic          r_drain;
    logic          r_busy;
    logic          r_done;
    logic          r_conflict;
    logic [W-1:0]  r_d1;
    logic          r_v1;
    logic          r_l1;

    logic          w_run;
    logic          w_issue;
    logic          w_last_beat;
    logic [AW-1:0] w_rd_addr;

    assign w_run       = (r_state == RUN);
    assign w_issue     = w_run | (bus.rd_en & (r_state == IDLE));
    assign w_last_beat = ((r_cnt + ONE) == r_len);
    assign w_rd_addr   = w_run ? r_addr : bus.rd_addr;

    // Array contents are never reset. A cleared mask bit leaves that lane untouched.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wr_mask[i]) begin
                    r_mem[bus.wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= bus.wr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
        end else begin
            r_v1 <= w_issue;
            r_l1 <= w_run & w_last_beat;
            if (w_issue) begin
                r_d1 <= r_mem[w_rd_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_stride   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_drain    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.rd_en && r_busy) begin
                r_conflict <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.burst_start) begin
                        r_addr   <= bus.burst_base;
                        r_stride <= bus.burst_stride;
                        r_len    <= bus.burst_len;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_drain  <= DRAIN_INIT;
                        r_state  <= (bus.burst_len == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    r_addr <= r_addr + r_stride;
                    r_cnt  <= r_cnt + ONE;
                    if (w_last_beat) begin
                        r_state <= DRAIN;
                        r_drain <= DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    // Wait out the read pipeline so done lands one cycle after the last valid.
                    if (r_drain == 1'b0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VEC_BRAM_OUTREG_EN
    logic [W-1:0] r_d2;
    logic         r_v2;
    logic         r_l2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d2 <= '0;
            r_v2 <= 1'b0;
            r_l2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            if (r_v1) begin
                r_d2 <= r_d1;
            end
        end
    end

    assign bus.rd_data  = r_d2;
    assign bus.rd_valid = r_v2;
    assign bus.rd_last  = r_l2;
`else
    assign bus.rd_data  = r_d1;
    assign bus.rd_valid = r_v1;
    assign bus.rd_last  = r_l1;
`endif

    assign bus.burst_busy  = r_busy;
    assign bus.burst_done  = r_done;
    assign bus.rd_conflict = r_conflict;
endmodule

// File: tb/tb_vec_bram.sv
// Directed bench for vec_bram: table-driven single-beat vectors plus hand-written burst and reset sequences.
module tb_vec_bram;
`ifdef VEC_BRAM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vec_bram_if #(.LANE_WIDTH(32), .LANES(4), .DEPTH(256)) bus ();

    vec_bram #(.LANE_WIDTH(32), .LANES(4), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic         we;
        logic [7:0]   waddr;
        logic [127:0] wdata;
        logic [3:0]   wmask;
        logic         re;
        logic [7:0]   raddr;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int a);
        return {32'(a) + 32'h3000, 32'(a) + 32'h2000, 32'(a) + 32'h1000, 32'(a)};
    endfunction

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        bus.burst_start = 1'b0; bus.burst_base = '0; bus.burst_len = '0; bus.burst_stride = '0;
    endtask

    task automatic write_word(input int a, input logic [127:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 8'(a); bus.wr_data = d; bus.wr_mask = 4'hF;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Cycle c counts from the edge that sampled burst_start (c=1 is the first busy cycle).
    task automatic do_burst(input int base, input int stride, input int len, input int poke_c);
        int k;
        logic [3:0] exp_st;
        @(negedge clk);
        bus.burst_start = 1'b1; bus.burst_base = 8'(base);
        bus.burst_stride = 8'(stride); bus.burst_len = 9'(len);
        @(negedge clk);
        bus.burst_start = 1'b0;
        for (int c = 1; c <= len + L + 2; c++) begin
            if (c > 1) @(negedge clk);
            k = c - 1 - L;
            exp_st[3] = (c <= len + L);
            exp_st[2] = (k >= 0) && (k < len);
            exp_st[1] = (k == len - 1) && (len > 0);
            exp_st[0] = (c == len + L + 1);
            chk($sformatf("burst b%0d s%0d n%0d c%0d busy/vld/last/done", base, stride, len, c),
                {bus.burst_busy, bus.rd_valid, bus.rd_last, bus.burst_done}, exp_st);
            if (exp_st[2]) begin
                chk($sformatf("burst b%0d s%0d n%0d beat%0d data", base, stride, len, k),
                    bus.rd_data, pat((base + k * stride) % 256));
            end
            bus.rd_en = (c == poke_c); bus.rd_addr = 8'd200;
            bus.burst_start = (c == poke_c); bus.burst_base = 8'd100;
            bus.burst_len = 9'd5; bus.burst_stride = 8'd3;
        end
        bus.rd_en = 1'b0;
        bus.burst_start = 1'b0;
    endtask

    initial begin
        idle_inputs();
        vecs[0] = '{1'b1, 8'd5, {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111, 1'b0, 8'd0, 128'h0};
        vecs[1] = '{1'b1, 8'd5, {32'hD, 32'hC, 32'hB, 32'hA}, 4'b0101, 1'b0, 8'd0, 128'h0};
        vecs[2] = '{1'b0, 8'd0, 128'h0, 4'b0000, 1'b1, 8'd5, {32'h4, 32'hC, 32'h2, 32'hA}};
        vecs[3] = '{1'b1, 8'd7, {4{32'h11111111}}, 4'b1111, 1'b0, 8'd0, 128'h0};
        vecs[4] = '{1'b1, 8'd7, {4{32'h22222222}}, 4'b1111, 1'b1, 8'd7, {4{32'h11111111}}};
        vecs[5] = '{1'b0, 8'd0, 128'h0, 4'b0000, 1'b1, 8'd7, {4{32'h22222222}}};
        vecs[6] = '{1'b1, 8'd7, {4{32'hFFFFFFFF}}, 4'b0000, 1'b0, 8'd0, 128'h0};
        vecs[7] = '{1'b0, 8'd0, 128'h0, 4'b0000, 1'b1, 8'd7, {4{32'h22222222}}};

        repeat (2) @(negedge clk);
        chk("reset outputs", {bus.rd_data, bus.rd_valid, bus.rd_last, bus.burst_busy,
            bus.burst_done, bus.rd_conflict} >> 5, 128'h0);
        chk("reset flags", {bus.rd_valid, bus.rd_last, bus.burst_busy, bus.burst_done, bus.rd_conflict}, 128'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.wr_en = vecs[i].we; bus.wr_addr = vecs[i].waddr;
            bus.wr_data = vecs[i].wdata; bus.wr_mask = vecs[i].wmask;
            bus.rd_en = vecs[i].re; bus.rd_addr = vecs[i].raddr;
            @(negedge clk);
            idle_inputs();
            repeat (L - 1) @(negedge clk);
            chk($sformatf("vec%0d valid/last", i), {bus.rd_valid, bus.rd_last}, {vecs[i].re, 1'b0});
            if (vecs[i].re) chk($sformatf("vec%0d data", i), bus.rd_data, vecs[i].exp);
        end

        for (int a = 0; a < 16; a++) write_word(a, pat(a));
        write_word(254, pat(254));
        write_word(255, pat(255));

        do_burst(0, 2, 8, 0);
        do_burst(254, 1, 4, 0);
        do_burst(3, 0, 3, 0);
        do_burst(9, 1, 0, 0);
        do_burst(1, 1, 1, 0);
        chk("conflict clear before poke", bus.rd_conflict, 1'b0);
        do_burst(1, 1, 8, 3);
        @(negedge clk);
        chk("conflict sticky", bus.rd_conflict, 1'b1);

        // Reset during beat 3 of an 8-beat burst.
        @(negedge clk);
        bus.burst_start = 1'b1; bus.burst_base = 8'd0; bus.burst_stride = 8'd1; bus.burst_len = 9'd8;
        @(negedge clk);
        bus.burst_start = 1'b0;
        repeat (2 + L) @(negedge clk);
        chk("pre-reset beat valid", bus.rd_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid-burst reset data", bus.rd_data, 128'h0);
        chk("mid-burst reset flags", {bus.rd_valid, bus.rd_last, bus.burst_busy, bus.burst_done, bus.rd_conflict}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset quiet c%0d", c), {bus.rd_valid, bus.burst_done, bus.burst_busy}, 128'h0);
        end
        do_burst(2, 3, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
